// File: rtl/mux_sel_ctrl.sv
// Pixel-layer mux select for a grid/splash display: grid line generation,
// splash/grid mode sequencing on frame boundaries and selection-highlight blinking.
module mux_sel_ctrl #(
  parameter int CELL_W        = 80,
  parameter int CELL_H        = 80,
  parameter int LINE_W        = 2,
  parameter int SPLASH_FRAMES = 120,
  parameter int BLINK_FRAMES  = 30
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] hcount,
  input  logic [9:0] vcount,
  input  logic       video_on,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       sprite_hit,
  input  logic       msg_hit,
  input  logic       slc_hit,
  output logic [2:0] selector,
  output logic       mode,
  output logic       blink
);

  localparam int CX_W = $clog2(CELL_W);
  localparam int CY_W = $clog2(CELL_H);
  localparam int SP_W = (SPLASH_FRAMES > 1) ? $clog2(SPLASH_FRAMES) : 1;
  localparam int BL_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CX_W-1:0] CX_LAST = CX_W'(CELL_W - 1);
  localparam logic [CY_W-1:0] CY_LAST = CY_W'(CELL_H - 1);
  localparam logic [CX_W-1:0] CX_LINE = CX_W'(LINE_W);
  localparam logic [CY_W-1:0] CY_LINE = CY_W'(LINE_W);
  localparam logic [SP_W-1:0] SP_LAST = SP_W'(SPLASH_FRAMES - 1);
  localparam logic [BL_W-1:0] BL_LAST = BL_W'(BLINK_FRAMES - 1);

  localparam logic [2:0] SEL_HLINE  = 3'b000;
  localparam logic [2:0] SEL_VLINE  = 3'b001;
  localparam logic [2:0] SEL_SPRITE = 3'b010;
  localparam logic [2:0] SEL_MSG    = 3'b011;
  localparam logic [2:0] SEL_SLC    = 3'b100;
  localparam logic [2:0] SEL_BLANK  = 3'b111;

  // state    | meaning
  // S_SPLASH | splash screen, only the message layer is shown
  // S_GRID   | grid with sprite and blinking selection layers
  typedef enum logic {
    S_SPLASH = 1'b0,
    S_GRID   = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [CX_W-1:0] r_cx;
  logic [CX_W-1:0] w_cx;
  logic [CY_W-1:0] r_cy;
  logic [CY_W-1:0] w_cy;
  logic [SP_W-1:0] r_spl_cnt;
  logic [BL_W-1:0] r_blk_cnt;
  logic            r_blink;
  logic            r_btn_d;
  logic            r_pend;
  logic [2:0]      r_sel;
  logic [2:0]      w_sel_nxt;
  logic            w_btn_rise;
  logic            w_line_start;
  logic            w_vline;
  logic            w_hline;

  // Counter values for the current pixel: restart on hcount 0 combinationally
  // so the first pixel of each line already sees column 0.
  assign w_cx         = (hcount == '0) ? '0 : r_cx;
  assign w_line_start = (hcount == '0) && (vcount != '0);
  assign w_cy         = w_line_start ? ((r_cy == CY_LAST) ? '0 : r_cy + 1'b1) : r_cy;
  assign w_vline      = (w_cx < CX_LINE);
  assign w_hline      = (w_cy < CY_LINE);
  assign w_btn_rise   = start_btn & ~r_btn_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cx <= '0;
      r_cy <= '0;
    end else begin
      r_cx <= (w_cx == CX_LAST) ? '0 : w_cx + 1'b1;
      r_cy <= frame_tick ? '0 : w_cy;
    end
  end

  // An edge coinciding with frame_tick is kept for the following frame_tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_btn_d <= 1'b0;
      r_pend  <= 1'b0;
    end else begin
      r_btn_d <= start_btn;
      if (frame_tick) begin
        r_pend <= w_btn_rise;
      end else if (w_btn_rise) begin
        r_pend <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_SPLASH;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    if (frame_tick) begin
      case (r_state)
        S_SPLASH: if ((r_spl_cnt == SP_LAST) || r_pend) w_state_nxt = S_GRID;
        S_GRID:   if (r_pend) w_state_nxt = S_SPLASH;
        default:  w_state_nxt = S_SPLASH;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_spl_cnt <= '0;
    end else if ((r_state == S_SPLASH) && (w_state_nxt == S_SPLASH)) begin
      if (frame_tick && (r_spl_cnt != SP_LAST)) begin
        r_spl_cnt <= r_spl_cnt + 1'b1;
      end
    end else begin
      r_spl_cnt <= '0;
    end
  end

  // Highlight is forced on whenever the next frame is a splash frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b1;
    end else if (w_state_nxt == S_SPLASH) begin
      r_blk_cnt <= '0;
      r_blink   <= 1'b1;
    end else if (frame_tick && (r_state == S_GRID)) begin
      if (r_blk_cnt == BL_LAST) begin
        r_blk_cnt <= '0;
        r_blink   <= ~r_blink;
      end else begin
        r_blk_cnt <= r_blk_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    w_sel_nxt = SEL_BLANK;
    if (video_on) begin
      if (r_state == S_GRID) begin
        if (slc_hit && r_blink) begin
          w_sel_nxt = SEL_SLC;
        end else if (sprite_hit) begin
          w_sel_nxt = SEL_SPRITE;
        end else if (w_hline) begin
          w_sel_nxt = SEL_HLINE;
        end else if (w_vline) begin
          w_sel_nxt = SEL_VLINE;
        end
      end else if (msg_hit) begin
        w_sel_nxt = SEL_MSG;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel <= SEL_BLANK;
    end else begin
      r_sel <= w_sel_nxt;
    end
  end

  assign selector = r_sel;
  assign mode     = (r_state == S_GRID);
  assign blink    = r_blink;

endmodule

// File: tb/tb_mux_sel_ctrl.sv
// Directed bench for mux_sel_ctrl: splash sequencing, grid lines, layer priority,
// blink cadence, start button handling, video blanking and async reset.
module tb_mux_sel_ctrl;

  localparam int SPLASH_FRAMES = 3;
  localparam int BLINK_FRAMES  = 2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [9:0] hcount;
  logic [9:0] vcount;
  logic       video_on;
  logic       frame_tick;
  logic       start_btn;
  logic       sprite_hit;
  logic       msg_hit;
  logic       slc_hit;
  logic [2:0] selector;
  logic       mode;
  logic       blink;

  int total = 0;
  int bad   = 0;

  mux_sel_ctrl #(
    .CELL_W(80), .CELL_H(80), .LINE_W(2),
    .SPLASH_FRAMES(SPLASH_FRAMES), .BLINK_FRAMES(BLINK_FRAMES)
  ) dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount),
    .video_on(video_on), .frame_tick(frame_tick), .start_btn(start_btn),
    .sprite_hit(sprite_hit), .msg_hit(msg_hit), .slc_hit(slc_hit),
    .selector(selector), .mode(mode), .blink(blink)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_frame();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    hcount = 10'd5; vcount = 10'd5;
    video_on = 1'b0; frame_tick = 1'b0; start_btn = 1'b0;
    sprite_hit = 1'b0; msg_hit = 1'b0; slc_hit = 1'b0;
    #12;
    total++; if (selector !== 3'b111) begin bad++; $display("FAIL reset_sel got=%b want=111", selector); end
    total++; if (mode !== 1'b0) begin bad++; $display("FAIL reset_mode got=%b want=0", mode); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL reset_blink got=%b want=1", blink); end
    step();
    rst_n = 1'b1;
  endtask

  task automatic test_splash();
    logic exp_m;
    video_on = 1'b1; msg_hit = 1'b0; sprite_hit = 1'b1;
    step();
    total++; if (selector !== 3'b111) begin bad++; $display("FAIL splash_no_msg got=%b want=111", selector); end
    sprite_hit = 1'b0; msg_hit = 1'b1;
    for (int f = 0; f < 3; f++) begin
      step();
      total++; if (selector !== 3'b011) begin bad++; $display("FAIL splash_sel f=%0d got=%b want=011", f, selector); end
      tick_frame();
      exp_m = (f == 2);
      total++; if (mode !== exp_m) begin bad++; $display("FAIL splash_mode f=%0d got=%b want=%b", f, mode, exp_m); end
    end
    msg_hit = 1'b0;
  endtask

  task automatic test_vline();
    logic [2:0] exp_s;
    video_on = 1'b0; hcount = 10'd0; vcount = 10'd1;
    repeat (39) step();
    video_on = 1'b1;
    for (int h = 0; h < 162; h++) begin
      hcount = 10'(h);
      step();
      exp_s = ((h % 80) < 2) ? 3'b001 : 3'b111;
      total++; if (selector !== exp_s) begin bad++; $display("FAIL vline h=%0d got=%b want=%b", h, selector, exp_s); end
    end
  endtask

  task automatic test_hline();
    logic [9:0] hv [7];
    logic [2:0] ev [7];
    hv = '{10'd0, 10'd5, 10'd40, 10'd0, 10'd0, 10'd7, 10'd7};
    ev = '{3'b000, 3'b000, 3'b000, 3'b000, 3'b001, 3'b001, 3'b111};
    video_on = 1'b0; hcount = 10'd0; vcount = 10'd1;
    repeat (39) step();
    video_on = 1'b1;
    for (int i = 0; i < 7; i++) begin
      hcount = hv[i];
      step();
      total++; if (selector !== ev[i]) begin bad++; $display("FAIL hline i=%0d got=%b want=%b", i, selector, ev[i]); end
    end
  endtask

  task automatic test_priority();
    logic sv [4];
    logic cv [4];
    logic [2:0] ev [4];
    sv = '{1'b1, 1'b0, 1'b1, 1'b0};
    cv = '{1'b1, 1'b1, 1'b0, 1'b0};
    ev = '{3'b100, 3'b100, 3'b010, 3'b001};
    hcount = 10'd0; vcount = 10'd0; video_on = 1'b1;
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL prio_blink_init got=%b want=1", blink); end
    for (int i = 0; i < 4; i++) begin
      sprite_hit = sv[i]; slc_hit = cv[i];
      step();
      total++; if (selector !== ev[i]) begin bad++; $display("FAIL prio_blink1 i=%0d got=%b want=%b", i, selector, ev[i]); end
    end
    sprite_hit = 1'b0; slc_hit = 1'b0;
    tick_frame();
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL prio_blink_t1 got=%b want=1", blink); end
    tick_frame();
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL prio_blink_t2 got=%b want=0", blink); end
    ev = '{3'b010, 3'b000, 3'b010, 3'b000};
    for (int i = 0; i < 4; i++) begin
      sprite_hit = sv[i]; slc_hit = cv[i];
      step();
      total++; if (selector !== ev[i]) begin bad++; $display("FAIL prio_blink0 i=%0d got=%b want=%b", i, selector, ev[i]); end
    end
    sprite_hit = 1'b0; slc_hit = 1'b0;
    total++; if (mode !== 1'b1) begin bad++; $display("FAIL prio_mode got=%b want=1", mode); end
  endtask

  task automatic test_blink();
    logic ev [4];
    ev = '{1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 4; i++) begin
      step();
      tick_frame();
      total++; if (blink !== ev[i]) begin bad++; $display("FAIL blink_seq i=%0d got=%b want=%b", i, blink, ev[i]); end
    end
  endtask

  task automatic test_start_btn();
    logic em [3];
    em = '{1'b0, 1'b0, 1'b1};
    hcount = 10'd5; vcount = 10'd5; video_on = 1'b1;
    start_btn = 1'b1;
    step();
    total++; if (mode !== 1'b1) begin bad++; $display("FAIL btn_mid_frame got=%b want=1", mode); end
    start_btn = 1'b0; step();
    start_btn = 1'b1; step();
    start_btn = 1'b0;
    repeat (3) step();
    total++; if (mode !== 1'b1) begin bad++; $display("FAIL btn_hold_mode got=%b want=1", mode); end
    tick_frame();
    total++; if (mode !== 1'b0) begin bad++; $display("FAIL btn_to_splash got=%b want=0", mode); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL btn_splash_blink got=%b want=1", blink); end
    sprite_hit = 1'b1;
    step();
    total++; if (selector !== 3'b111) begin bad++; $display("FAIL btn_splash_sprite got=%b want=111", selector); end
    sprite_hit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      tick_frame();
      total++; if (mode !== em[i]) begin bad++; $display("FAIL btn_splash_cnt i=%0d got=%b want=%b", i, mode, em[i]); end
    end
  endtask

  task automatic test_simul();
    start_btn = 1'b1; frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    total++; if (mode !== 1'b1) begin bad++; $display("FAIL simul_same_tick got=%b want=1", mode); end
    repeat (3) step();
    tick_frame();
    total++; if (mode !== 1'b0) begin bad++; $display("FAIL simul_next_tick got=%b want=0", mode); end
    start_btn = 1'b0; step();
    start_btn = 1'b1; step();
    start_btn = 1'b0; step();
    tick_frame();
    total++; if (mode !== 1'b1) begin bad++; $display("FAIL simul_early_exit got=%b want=1", mode); end
  endtask

  task automatic test_video_off();
    hcount = 10'd0; vcount = 10'd0;
    video_on = 1'b0; sprite_hit = 1'b1; msg_hit = 1'b1; slc_hit = 1'b1;
    step();
    total++; if (selector !== 3'b111) begin bad++; $display("FAIL voff_grid got=%b want=111", selector); end
    video_on = 1'b1;
    step();
    total++; if (selector !== 3'b100) begin bad++; $display("FAIL von_grid got=%b want=100", selector); end
    tick_frame();
    tick_frame();
    step();
    total++; if (blink !== 1'b0) begin bad++; $display("FAIL voff_blink got=%b want=0", blink); end
    total++; if (selector !== 3'b010) begin bad++; $display("FAIL von_grid_b0 got=%b want=010", selector); end
    rst_n = 1'b0;
    #2;
    total++; if (selector !== 3'b111) begin bad++; $display("FAIL async_rst_sel got=%b want=111", selector); end
    total++; if (mode !== 1'b0) begin bad++; $display("FAIL async_rst_mode got=%b want=0", mode); end
    total++; if (blink !== 1'b1) begin bad++; $display("FAIL async_rst_blink got=%b want=1", blink); end
    step();
    rst_n = 1'b1;
    video_on = 1'b0;
    step();
    total++; if (selector !== 3'b111) begin bad++; $display("FAIL voff_splash got=%b want=111", selector); end
    video_on = 1'b1;
    step();
    total++; if (selector !== 3'b011) begin bad++; $display("FAIL von_splash got=%b want=011", selector); end
    tick_frame();
    total++; if (mode !== 1'b0) begin bad++; $display("FAIL post_rst_mode got=%b want=0", mode); end
  endtask

  initial begin
    test_reset();
    test_splash();
    test_vline();
    test_hline();
    test_priority();
    test_blink();
    test_start_btn();
    test_simul();
    test_video_off();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
